bram_arbiter: RTL and testbench

Two-requester arbiter sharing one port of the dual-port block RAM between the instruction-fetch path (requester 0) and the load/store path (requester 1) of the LEG core. It accepts one read or write per cycle using valid/ready handshakes, applies round-robin arbitration under contention, and supports a lock for atomic read-modify-write sequences. It routes the one-cycle-latency read data back to whichever requester issued the read.

---
 rtl/leg_mem_pkg.sv | 16 +
 rtl/rr_arb2.sv | 21 ++
 rtl/bram_arbiter.sv | 126 ++++++++++++
 tb/tb_bram_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/leg_mem_pkg.sv
// Shared types for the LEG core memory path:
// requester IDs and the BRAM arbiter state encoding.
package leg_mem_pkg;

  typedef enum logic [0:0] {
    REQ_IFETCH = 1'b0,
    REQ_LSU    = 1'b1
  } req_id_e;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: under contention the
// pointer's requester wins, otherwise the lone valid one.
module rr_arb2
  import leg_mem_pkg::*;
(
  input  logic [1:0] valid_i,
  input  logic       ptr_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    case (valid_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = ptr_i ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/bram_arbiter.sv
// Shares one BRAM port between instruction fetch and
// load/store, with round-robin, lock and read routing.
module bram_arbiter
  import leg_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req0_valid,
  input  logic                  i_req0_write,
  input  logic [ADDR_WIDTH-1:0] i_req0_addr,
  input  logic [DATA_WIDTH-1:0] i_req0_data,
  input  logic                  i_req0_lock,
  output logic                  o_req0_ready,
  output logic                  o_rsp0_valid,
  output logic [DATA_WIDTH-1:0] o_rsp0_data,
  input  logic                  i_req1_valid,
  input  logic                  i_req1_write,
  input  logic [ADDR_WIDTH-1:0] i_req1_addr,
  input  logic [DATA_WIDTH-1:0] i_req1_data,
  input  logic                  i_req1_lock,
  output logic                  o_req1_ready,
  output logic                  o_rsp1_valid,
  output logic [DATA_WIDTH-1:0] o_rsp1_data,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_data,
  output logic                  o_mem_write,
  input  logic [DATA_WIDTH-1:0] i_mem_data
);

  arb_state_e state_q;
  req_id_e    ptr_q;
  req_id_e    owner_q;
  logic       pend_q;

  logic [1:0] vld;
  logic [1:0] arb_gnt;
  logic [1:0] gnt;

  assign vld = {i_req1_valid, i_req0_valid};

  rr_arb2 u_rr (
    .valid_i (vld),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt)
  );

  // A lock restricts the grant to its holder only.
  always_comb begin
    gnt = 2'b00;
    unique case (state_q)
      ARB:     gnt = arb_gnt;
      LOCK0:   gnt = {1'b0, vld[0]};
      LOCK1:   gnt = {vld[1], 1'b0};
      default: gnt = 2'b00;
    endcase
    if (i_rst) gnt = 2'b00;
  end

  assign o_req0_ready = gnt[0];
  assign o_req1_ready = gnt[1];

  always_comb begin
    o_mem_addr  = '0;
    o_mem_data  = '0;
    o_mem_write = 1'b0;
    if (gnt[0]) begin
      o_mem_addr  = i_req0_addr;
      o_mem_data  = i_req0_data;
      o_mem_write = i_req0_write;
    end else if (gnt[1]) begin
      o_mem_addr  = i_req1_addr;
      o_mem_data  = i_req1_data;
      o_mem_write = i_req1_write;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ARB;
      ptr_q   <= REQ_IFETCH;
      owner_q <= REQ_IFETCH;
      pend_q  <= 1'b0;
    end else begin
      pend_q  <= (gnt[0] & ~i_req0_write)
               | (gnt[1] & ~i_req1_write);
      owner_q <= gnt[1] ? REQ_LSU : REQ_IFETCH;
      unique case (state_q)
        ARB: begin
          if (gnt[0]) begin
            if (&vld) ptr_q <= REQ_LSU;
            if (i_req0_lock) state_q <= LOCK0;
          end else if (gnt[1]) begin
            if (&vld) ptr_q <= REQ_IFETCH;
            if (i_req1_lock) state_q <= LOCK1;
          end
        end
        LOCK0: begin
          if (!vld[0]) begin
            state_q <= ARB;
          end else if (!i_req0_lock) begin
            state_q <= ARB;
            ptr_q   <= REQ_LSU;
          end
        end
        LOCK1: begin
          if (!vld[1]) begin
            state_q <= ARB;
          end else if (!i_req1_lock) begin
            state_q <= ARB;
            ptr_q   <= REQ_IFETCH;
          end
        end
        default: state_q <= ARB;
      endcase
    end
  end

  assign o_rsp0_valid = pend_q & (owner_q == REQ_IFETCH);
  assign o_rsp1_valid = pend_q & (owner_q == REQ_LSU);
  assign o_rsp0_data  = i_mem_data;
  assign o_rsp1_data  = i_mem_data;

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter with a BRAM model and
// a response scoreboard checked by a separate monitor.
module tb_bram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        v0, w0, l0, v1, w1, l1;
  logic [9:0]  a0, a1;
  logic [31:0] d0, d1;
  logic        rdy0, rdy1, rv0, rv1, mwr;
  logic [31:0] rd0, rd1, mdat, mrd;
  logic [9:0]  maddr;

  logic [31:0] ram [0:1023];

  typedef struct {
    logic        owner;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   vecs = 0;
  int   miss = 0;
  bit   mon_en = 1'b0;

  always #5 clk = ~clk;

  bram_arbiter dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req0_valid (v0),
    .i_req0_write (w0),
    .i_req0_addr  (a0),
    .i_req0_data  (d0),
    .i_req0_lock  (l0),
    .o_req0_ready (rdy0),
    .o_rsp0_valid (rv0),
    .o_rsp0_data  (rd0),
    .i_req1_valid (v1),
    .i_req1_write (w1),
    .i_req1_addr  (a1),
    .i_req1_data  (d1),
    .i_req1_lock  (l1),
    .o_req1_ready (rdy1),
    .o_rsp1_valid (rv1),
    .o_rsp1_data  (rd1),
    .o_mem_addr   (maddr),
    .o_mem_data   (mdat),
    .o_mem_write  (mwr),
    .i_mem_data   (mrd)
  );

  // Synchronous single-cycle-latency RAM on port A.
  always @(posedge clk) begin
    if (mwr) ram[maddr] <= mdat;
    mrd <= ram[maddr];
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      logic        e0, e1;
      logic [31:0] ed;
      exp_t        e;
      e0 = 1'b0;
      e1 = 1'b0;
      ed = '0;
      if (q.size() > 0 && q[0].due == cyc) begin
        e  = q.pop_front();
        e0 = ~e.owner;
        e1 = e.owner;
        ed = e.data;
      end
      check("rsp0_valid", {31'd0, rv0}, {31'd0, e0});
      check("rsp1_valid", {31'd0, rv1}, {31'd0, e1});
      if (e0) check("rsp0_data", rd0, ed);
      if (e1) check("rsp1_data", rd1, ed);
    end
  end

  task automatic step(
    input string       nm,
    input logic        r,
    input logic        iv0, iw0, il0,
    input logic [9:0]  ia0,
    input logic [31:0] id0,
    input logic        iv1, iw1, il1,
    input logic [9:0]  ia1,
    input logic [31:0] id1,
    input logic        er0, er1,
    input logic [31:0] ed
  );
    logic        ew;
    logic [9:0]  ea;
    exp_t        e;
    @(posedge clk);
    #1;
    rst = r;
    v0 = iv0; w0 = iw0; l0 = il0; a0 = ia0; d0 = id0;
    v1 = iv1; w1 = iw1; l1 = il1; a1 = ia1; d1 = id1;
    @(negedge clk);
    ew = (er0 & iw0) | (er1 & iw1);
    ea = er0 ? ia0 : (er1 ? ia1 : 10'd0);
    check({nm, ".ready0"}, {31'd0, rdy0}, {31'd0, er0});
    check({nm, ".ready1"}, {31'd0, rdy1}, {31'd0, er1});
    check({nm, ".mem_write"}, {31'd0, mwr}, {31'd0, ew});
    check({nm, ".mem_addr"}, {22'd0, maddr}, {22'd0, ea});
    if ((er0 && !iw0) || (er1 && !iw1)) begin
      e.owner = er1;
      e.data  = ed;
      e.due   = cyc + 1;
      q.push_back(e);
    end
  endtask

  localparam logic [31:0] Z = 32'd0;

  initial begin
    for (int i = 0; i < 1024; i++)
      ram[i] = 32'h1000_0000 + i;
    ram[5] = 32'hDEAD_BEEF;
    rst = 1'b1;
    v0 = 0; w0 = 0; l0 = 0; a0 = 0; d0 = 0;
    v1 = 0; w1 = 0; l1 = 0; a1 = 0; d1 = 0;

    step("rst_a", 1, 0,0,0, 10'd0, Z, 0,0,0, 10'd0, Z, 0,0, Z);
    mon_en = 1'b1;
    step("rst_b", 1, 1,0,0, 10'd1, Z, 1,0,0, 10'd2, Z, 0,0, Z);

    // single read from requester 0
    step("rd5", 0, 1,0,0, 10'd5, Z, 0,0,0, 10'd0, Z,
         1,0, 32'hDEAD_BEEF);
    step("idle1", 0, 0,0,0, 10'd0, Z, 0,0,0, 10'd0, Z, 0,0, Z);

    // constant contention: grants 0,1,0,1
    step("ct1", 0, 1,0,0, 10'd10, Z, 1,0,0, 10'd20, Z,
         1,0, 32'h1000_000A);
    step("ct2", 0, 1,0,0, 10'd10, Z, 1,0,0, 10'd20, Z,
         0,1, 32'h1000_0014);
    step("ct3", 0, 1,0,0, 10'd11, Z, 1,0,0, 10'd20, Z,
         1,0, 32'h1000_000B);
    step("ct4", 0, 1,0,0, 10'd11, Z, 1,0,0, 10'd21, Z,
         0,1, 32'h1000_0015);

    // write then read-back of the same address
    step("wr7", 0, 0,0,0, 10'd0, Z, 1,1,0, 10'd7, 32'h1234,
         0,1, Z);
    step("rd7", 0, 0,0,0, 10'd0, Z, 1,0,0, 10'd7, Z,
         0,1, 32'h0000_1234);

    // requester 1 locks across a read-modify-write
    step("lk_a", 0, 1,0,0, 10'd1, Z, 1,0,1, 10'd8, Z,
         1,0, 32'h1000_0001);
    step("lk_rd", 0, 1,0,0, 10'd1, Z, 1,0,1, 10'd8, Z,
         0,1, 32'h1000_0008);
    step("lk_wr", 0, 1,0,0, 10'd1, Z, 1,1,0, 10'd9, 32'hCAFE,
         0,1, Z);
    step("lk_after", 0, 1,0,0, 10'd1, Z, 1,0,0, 10'd9, Z,
         1,0, 32'h1000_0001);
    step("rd9", 0, 0,0,0, 10'd0, Z, 1,0,0, 10'd9, Z,
         0,1, 32'h0000_CAFE);

    // requester 0 locks, then drops valid
    step("lk0", 0, 1,0,1, 10'd2, Z, 0,0,0, 10'd0, Z,
         1,0, 32'h1000_0002);
    step("lk0_drop", 0, 0,0,0, 10'd0, Z, 1,0,0, 10'd3, Z,
         0,0, Z);
    step("lk0_rel", 0, 0,0,0, 10'd0, Z, 1,0,0, 10'd3, Z,
         0,1, 32'h1000_0003);

    // reset during a valid read, pointer back to 0
    step("rst_rd", 1, 1,0,0, 10'd4, Z, 0,0,0, 10'd0, Z, 0,0, Z);
    step("rst_wr", 1, 1,1,0, 10'd4, 32'h5555, 0,0,0, 10'd0, Z,
         0,0, Z);
    step("post_rst", 0, 1,0,0, 10'd12, Z, 1,0,0, 10'd13, Z,
         1,0, 32'h1000_000C);
    step("rd4", 0, 0,0,0, 10'd0, Z, 1,0,0, 10'd4, Z,
         0,1, 32'h1000_0004);

    step("idle2", 0, 0,0,0, 10'd0, Z, 0,0,0, 10'd0, Z, 0,0, Z);
    step("idle3", 0, 0,0,0, 10'd0, Z, 0,0,0, 10'd0, Z, 0,0, Z);
    step("idle4", 0, 0,0,0, 10'd0, Z, 0,0,0, 10'd0, Z, 0,0, Z);

    check("queue_drained", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, miss);
    $finish;
  end

endmodule
